// File: rtl/ajc_alu_pkg.sv
// Shared definitions for the sequential ALU: function codes, FSM state encoding
// and flag bit positions inside the {C,N,V,Z} flag word.
package ajc_alu_pkg;

    localparam logic [3:0] FN_ADD    = 4'b0000;
    localparam logic [3:0] FN_ADC    = 4'b0001;
    localparam logic [3:0] FN_SUB    = 4'b0010;
    localparam logic [3:0] FN_ADDK   = 4'b0011;
    localparam logic [3:0] FN_AND    = 4'b0100;
    localparam logic [3:0] FN_OR     = 4'b0101;
    localparam logic [3:0] FN_XOR    = 4'b0110;
    localparam logic [3:0] FN_NOT    = 4'b0111;
    localparam logic [3:0] FN_SHL    = 4'b1000;
    localparam logic [3:0] FN_SHR    = 4'b1001;
    localparam logic [3:0] FN_ASR    = 4'b1010;
    localparam logic [3:0] FN_ROR    = 4'b1011;
    localparam logic [3:0] FN_MULLO  = 4'b1100;
    localparam logic [3:0] FN_MULHI  = 4'b1101;
    localparam logic [3:0] FN_CONST0 = 4'b1110;
    localparam logic [3:0] FN_CONST1 = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam int FLG_C = 3;
    localparam int FLG_N = 2;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 0;

    function automatic logic is_shift(input logic [3:0] fn);
        return fn[3:2] == 2'b10;
    endfunction

    function automatic logic is_mul(input logic [3:0] fn);
        return fn[3:1] == 3'b110;
    endfunction

endpackage

// File: rtl/ajc_nbit_addsub_v.sv
// Combinational WIDTH-bit adder/subtractor; subtraction is a + ~b + 1, so
// cout=1 on a subtract means no borrow.
module ajc_nbit_addsub_v
    import ajc_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    always_comb begin
        b_eff = sub_i ? ~b_i : b_i;
        full  = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (sub_i | cin_i)};
    end

    assign sum_o  = full[WIDTH-1:0];
    assign cout_o = full[WIDTH];
    assign ovf_o  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (full[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/ajc_nbit_seq_alu.sv
// Registered multi-cycle ALU with Start/Busy/Done handshake: single-cycle
// arith/logic/const, one-bit-per-cycle shifts and a shift-add unsigned multiply.
module ajc_nbit_seq_alu
    import ajc_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K_W   = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [3:0]       Func_Sel,
    input  logic [WIDTH-1:0] Operand_X,
    input  logic [WIDTH-1:0] Operand_Y,
    input  logic [K_W-1:0]   Const_K,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [3:0]       ALU_CNVZ
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [3:0]         fn_q, fn_d;
    logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               cin_q, cin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               shc_q, shc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         cnvz_q, cnvz_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   add_a, add_b, add_sum;
    logic               add_cin, add_sub, add_cout, add_ovf;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c, fin_v;
    logic [SH_W-1:0]    sh_amt;

    // One adder serves both the arithmetic ops in FIN and the MUL accumulate step.
    always_comb begin
        add_a   = x_q;
        add_b   = y_q;
        add_cin = 1'b0;
        add_sub = 1'b0;
        if (state_q == ST_MUL) begin
            add_a = hi_q;
            add_b = lo_q[0] ? x_q : '0;
        end else begin
            case (fn_q)
                FN_ADC:  add_cin = cin_q;
                FN_SUB:  add_sub = 1'b1;
                FN_ADDK: add_b   = WIDTH'(k_q);
                default: ;
            endcase
        end
    end

    ajc_nbit_addsub_v #(.WIDTH(WIDTH)) u_addsub (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sub_i  (add_sub),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .ovf_o  (add_ovf)
    );

    always_comb begin
        fin_res = '0;
        fin_c   = 1'b0;
        fin_v   = 1'b0;
        case (fn_q)
            FN_ADD, FN_ADC, FN_SUB, FN_ADDK: begin
                fin_res = add_sum;
                fin_c   = add_cout;
                fin_v   = add_ovf;
            end
            FN_AND:  fin_res = x_q & y_q;
            FN_OR:   fin_res = x_q | y_q;
            FN_XOR:  fin_res = x_q ^ y_q;
            FN_NOT:  fin_res = ~x_q;
            FN_SHL, FN_SHR, FN_ASR, FN_ROR: begin
                fin_res = sh_q;
                fin_c   = shc_q;
            end
            FN_MULLO: begin
                fin_res = lo_q;
                fin_c   = |hi_q;
                fin_v   = |hi_q;
            end
            FN_MULHI:  fin_res = hi_q;
            FN_CONST1: fin_res = '1;
            default:   fin_res = '0;
        endcase
    end

    assign sh_amt = Operand_Y[SH_W-1:0];

    always_comb begin
        state_d = state_q;
        fn_d    = fn_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        shc_d   = shc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        cnvz_d  = cnvz_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A Start arriving in the Done cycle is dropped, giving latency+1 throughput.
                if (Start && !done_q) begin
                    fn_d  = Func_Sel;
                    x_d   = Operand_X;
                    y_d   = Operand_Y;
                    k_d   = Const_K;
                    cin_d = Cin;
                    sh_d  = Operand_X;
                    shc_d = 1'b0;
                    hi_d  = '0;
                    lo_d  = Operand_Y;
                    if (is_shift(Func_Sel)) begin
                        cnt_d   = CNT_W'(sh_amt);
                        state_d = (sh_amt == '0) ? ST_FIN : ST_SHIFT;
                    end else if (is_mul(Func_Sel)) begin
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = ST_MUL;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_SHIFT: begin
                case (fn_q)
                    FN_SHL: begin
                        shc_d = sh_q[WIDTH-1];
                        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                    end
                    FN_SHR: begin
                        shc_d = sh_q[0];
                        sh_d  = {1'b0, sh_q[WIDTH-1:1]};
                    end
                    FN_ASR: begin
                        shc_d = sh_q[0];
                        sh_d  = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                    end
                    default: begin
                        shc_d = sh_q[0];
                        sh_d  = {sh_q[0], sh_q[WIDTH-1:1]};
                    end
                endcase
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_FIN;
            end
            ST_MUL: begin
                // {cout, sum, lo} shifted right one place; lo holds the unconsumed multiplier bits.
                hi_d  = {add_cout, add_sum[WIDTH-1:1]};
                lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_FIN;
            end
            ST_FIN: begin
                res_d         = fin_res;
                cnvz_d[FLG_C] = fin_c;
                cnvz_d[FLG_N] = fin_res[WIDTH-1];
                cnvz_d[FLG_V] = fin_v;
                cnvz_d[FLG_Z] = (fin_res == '0);
                done_d        = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            fn_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            k_q    <= '0;
            cin_q  <= 1'b0;
            cnt_q  <= '0;
            sh_q   <= '0;
            shc_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            res_q  <= '0;
            cnvz_q <= '0;
            done_q <= 1'b0;
        end else begin
            fn_q   <= fn_d;
            x_q    <= x_d;
            y_q    <= y_d;
            k_q    <= k_d;
            cin_q  <= cin_d;
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            shc_q  <= shc_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            res_q  <= res_d;
            cnvz_q <= cnvz_d;
            done_q <= done_d;
        end
    end

    assign Busy       = (state_q != ST_IDLE);
    assign Done       = done_q;
    assign ALU_Result = res_q;
    assign ALU_CNVZ   = cnvz_q;

endmodule

// File: tb/tb_ajc_nbit_seq_alu.sv
// Directed bench for ajc_nbit_seq_alu at WIDTH=8 with hand-computed results,
// flags and Start-to-Done latencies.
module tb_ajc_nbit_seq_alu;
    import ajc_alu_pkg::*;

    logic       Clock;
    logic       Resetn;
    logic       Start;
    logic [3:0] Func_Sel;
    logic [7:0] Operand_X;
    logic [7:0] Operand_Y;
    logic [1:0] Const_K;
    logic       Cin;
    logic       Busy;
    logic       Done;
    logic [7:0] ALU_Result;
    logic [3:0] ALU_CNVZ;

    int vectors;
    int miscompares;

    ajc_nbit_seq_alu #(.WIDTH(8), .K_W(2)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Start      (Start),
        .Func_Sel   (Func_Sel),
        .Operand_X  (Operand_X),
        .Operand_Y  (Operand_Y),
        .Const_K    (Const_K),
        .Cin        (Cin),
        .Busy       (Busy),
        .Done       (Done),
        .ALU_Result (ALU_Result),
        .ALU_CNVZ   (ALU_CNVZ)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one operation, waits (bounded) for Done and checks latency, result and flags.
    task automatic run_op(input string tag, input logic [3:0] fn, input logic [7:0] x,
                          input logic [7:0] y, input logic [1:0] k, input logic ci,
                          input int lat, input logic [7:0] er, input logic [3:0] ef);
        int cyc;
        bit got;
        @(negedge Clock);
        Func_Sel  = fn;
        Operand_X = x;
        Operand_Y = y;
        Const_K   = k;
        Cin       = ci;
        Start     = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge Clock);
            cyc++;
            if (Done === 1'b1) got = 1'b1;
        end
        chk({tag, " done"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(lat));
        chk({tag, " result"}, 32'(ALU_Result), 32'(er));
        chk({tag, " cnvz"}, 32'(ALU_CNVZ), 32'(ef));
        chk({tag, " busy at done"}, 32'(Busy), 32'd0);
        @(negedge Clock);
        chk({tag, " done pulse"}, 32'(Done), 32'd0);
    endtask

    initial begin
        int cyc;
        int dones;
        logic [7:0] res_at_done;
        vectors     = 0;
        miscompares = 0;
        Resetn    = 1'b0;
        Start     = 1'b0;
        Func_Sel  = '0;
        Operand_X = '0;
        Operand_Y = '0;
        Const_K   = '0;
        Cin       = 1'b0;

        #12;
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset done", 32'(Done), 32'd0);
        chk("reset result", 32'(ALU_Result), 32'd0);
        chk("reset cnvz", 32'(ALU_CNVZ), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;

        run_op("add 7f+01",   FN_ADD,    8'h7F, 8'h01, 2'd0, 1'b0, 2,  8'h80, 4'b0110);
        run_op("sub 05-05",   FN_SUB,    8'h05, 8'h05, 2'd0, 1'b0, 2,  8'h00, 4'b1001);
        run_op("sub 03-05",   FN_SUB,    8'h03, 8'h05, 2'd0, 1'b0, 2,  8'hFE, 4'b0100);
        run_op("adc ff+00+1", FN_ADC,    8'hFF, 8'h00, 2'd0, 1'b1, 2,  8'h00, 4'b1001);
        run_op("addk fe+3",   FN_ADDK,   8'hFE, 8'h00, 2'd3, 1'b0, 2,  8'h01, 4'b1000);
        run_op("xor f0^f0",   FN_XOR,    8'hF0, 8'hF0, 2'd0, 1'b0, 2,  8'h00, 4'b0001);
        run_op("not 0f",      FN_NOT,    8'h0F, 8'h00, 2'd0, 1'b0, 2,  8'hF0, 4'b0100);
        run_op("const1",      FN_CONST1, 8'h12, 8'h34, 2'd0, 1'b1, 2,  8'hFF, 4'b0100);
        run_op("shl 81<<3",   FN_SHL,    8'h81, 8'h03, 2'd0, 1'b0, 5,  8'h08, 4'b0000);
        run_op("shl ff<<7",   FN_SHL,    8'hFF, 8'h07, 2'd0, 1'b0, 9,  8'h80, 4'b1100);
        run_op("ror 01>>1",   FN_ROR,    8'h01, 8'h01, 2'd0, 1'b0, 3,  8'h80, 4'b1100);
        run_op("asr 90>>2",   FN_ASR,    8'h90, 8'h02, 2'd0, 1'b0, 4,  8'hE4, 4'b0100);
        run_op("shr a5>>0",   FN_SHR,    8'hA5, 8'h00, 2'd0, 1'b0, 2,  8'hA5, 4'b0100);
        run_op("mullo 15*17", FN_MULLO,  8'd15, 8'd17, 2'd0, 1'b0, 10, 8'hFF, 4'b0100);
        run_op("mullo 16*16", FN_MULLO,  8'd16, 8'd16, 2'd0, 1'b0, 10, 8'h00, 4'b1011);
        run_op("mulhi 16*16", FN_MULHI,  8'd16, 8'd16, 2'd0, 1'b0, 10, 8'h01, 4'b0000);

        // Start held high for the whole of a MULLO; operands switched after acceptance.
        @(negedge Clock);
        Func_Sel  = FN_MULLO;
        Operand_X = 8'd3;
        Operand_Y = 8'd5;
        Cin       = 1'b0;
        Start     = 1'b1;
        @(posedge Clock);
        #1;
        Func_Sel  = FN_ADD;
        Operand_X = 8'hAA;
        Operand_Y = 8'h11;
        dones       = 0;
        res_at_done = 8'h00;
        for (cyc = 1; cyc <= 10; cyc++) begin
            @(negedge Clock);
            if (Done === 1'b1) begin
                dones++;
                res_at_done = ALU_Result;
            end
        end
        chk("stream done count", 32'(dones), 32'd1);
        chk("stream done at 10", 32'(Done), 32'd1);
        chk("stream result", 32'(res_at_done), 32'h0F);
        chk("stream cnvz", 32'(ALU_CNVZ), 32'(4'b0000));
        @(negedge Clock);
        chk("stream start in done cycle ignored", 32'(Busy), 32'd0);
        @(posedge Clock);
        #1 Start = 1'b0;
        @(negedge Clock);
        chk("stream next start accepted", 32'(Busy), 32'd1);
        @(negedge Clock);
        chk("stream next done", 32'(Done), 32'd1);
        chk("stream next result", 32'(ALU_Result), 32'hBB);
        chk("stream next cnvz", 32'(ALU_CNVZ), 32'(4'b0100));

        // Reset asserted in the fourth cycle of a MULLO.
        @(negedge Clock);
        Func_Sel  = FN_MULLO;
        Operand_X = 8'd16;
        Operand_Y = 8'd16;
        Start     = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("pre-reset busy", 32'(Busy), 32'd1);
        Resetn = 1'b0;
        #1;
        chk("abort busy", 32'(Busy), 32'd0);
        chk("abort done", 32'(Done), 32'd0);
        chk("abort result", 32'(ALU_Result), 32'd0);
        chk("abort cnvz", 32'(ALU_CNVZ), 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge Clock);
            if (Done === 1'b1) dones++;
        end
        chk("no done after abort", 32'(dones), 32'd0);
        run_op("add 02+03", FN_ADD, 8'h02, 8'h03, 2'd0, 1'b0, 2, 8'h05, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ajc_nbit_seq_alu.md
Name: ajc_nbit_seq_alu

Overview:
- Parametrised, registered, multi-cycle successor to the team's 8-bit combinational ALU. Keeps the same function groups (arithmetic, logic, shift/rotate, constant) and CNVZ flag semantics.
- Adds a Start/Busy/Done handshake, a registered result and flag register, variable-amount shifts and rotates, and a shift-add unsigned multiply.
- Sits between the register file read ports and the writeback mux of the RISC datapath, sequenced by the control FSM.

Parameters:
- WIDTH, 8, operand and result width in bits; any value 4 or greater. SH_W = clog2(WIDTH).
- K_W, 2, width of Const_K; zero-extended to WIDTH.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only when Busy=0.
- Func_Sel  in  4  operation code, latched at Start.
- Operand_X  in  WIDTH  operand X, latched at Start.
- Operand_Y  in  WIDTH  operand Y, latched at Start; for shifts, Y[SH_W-1:0] is the shift amount.
- Const_K  in  K_W  small constant, latched at Start.
- Cin  in  1  carry in, latched at Start.
- Busy  out  1  high while an operation is in progress.
- Done  out  1  one-cycle pulse; ALU_Result and ALU_CNVZ are valid in the same cycle.
- ALU_Result  out  WIDTH  registered result, held until the next Done.
- ALU_CNVZ  out  4  registered flags {C,N,V,Z}, held until the next Done.

Behaviour:
- Reset: asynchronous, active-low. All outputs, state and operand latches are 0 and the FSM goes to IDLE. Reset applied mid-operation aborts the operation; no Done is issued.
- Function codes:
  - 0000 ADD: X+Y
  - 0001 ADC: X+Y+Cin
  - 0010 SUB: X-Y, computed as X+~Y+1
  - 0011 ADDK: X+K
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOT X
  - 1000 SHL, 1001 SHR (logical), 1010 ASR, 1011 ROR; shift amount n = Y[SH_W-1:0]
  - 1100 MULLO: low WIDTH bits of X*Y (unsigned)
  - 1101 MULHI: high WIDTH bits of X*Y (unsigned)
  - 1110 CONST0: all zeros
  - 1111 CONST1: all ones
- FSM states: IDLE, SHIFT, MUL, FIN.
  - IDLE & Start: latch inputs, Busy=1 from the next cycle. Arith/logic/const ops go to FIN. Shift ops with n=0 go to FIN; with n>0 go to SHIFT with counter=n. MUL ops go to MUL with counter=WIDTH and accumulator=0.
  - SHIFT: one bit position per cycle; last bit out is captured into C; counter decrements; go to FIN when the counter reaches 1.
  - MUL: one shift-add step per cycle over 2*WIDTH bits; go to FIN after WIDTH steps.
  - FIN: write ALU_Result and ALU_CNVZ, pulse Done, Busy=0, return to IDLE. Done coincides with Busy falling.
- Latency from the Start edge to Done:
  - arith/logic/const: 2 cycles
  - shift: n+2 cycles (n=0 gives 2)
  - MUL: WIDTH+2 cycles
- Start while Busy=1: ignored; the operation in flight is not disturbed.
- Start in the same cycle as FIN: ignored. Back-to-back throughput is one operation per latency + 1 cycles.
- Flags, all ops: N = result MSB; Z = (result == 0).
- Arithmetic flags:
  - C = carry out; for SUB, C=1 means no borrow.
  - V = signed overflow of the WIDTH-bit operation.
- Logic and const flags: C=0, V=0.
- Shift flags: C = last bit shifted out (0 if n=0); V=0. ASR replicates the MSB. ROR has C = the bit that wrapped to the MSB.
- MUL flags:
  - MULLO: C = V = (high half != 0).
  - MULHI: C=0, V=0.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - K is zero-extended.
  - A shift amount of WIDTH-1 is legal; amounts beyond it cannot occur (SH_W bits).

Decomposition:
- Package ajc_alu_pkg holds:
  - function-code localparams (FN_ADD ... FN_CONST1)
  - the state encoding (ST_IDLE, ST_SHIFT, ST_MUL, ST_FIN)
  - flag bit indices (FLG_C=3, FLG_N=2, FLG_V=1, FLG_Z=0)
- One sub-module, ajc_nbit_addsub_v: WIDTH-parametrised combinational adder/subtractor with carry-out and overflow. It is used by the single-cycle arithmetic path and by the MUL accumulate step.
- Shift and MUL datapaths stay inline in the FSM.

Test Plan (WIDTH=8):
- ADD X=0x7F, Y=0x01 -> Done 2 cycles after Start, Result=0x80, CNVZ=0110.
- SUB X=0x05, Y=0x05 -> Result=0x00, CNVZ=1001. ADC X=0xFF, Y=0x00, Cin=1 -> Result=0x00, CNVZ=1001.
- Shifts:
  - SHL X=0x81, Y=3 -> Done at 5 cycles, Result=0x08, CNVZ=0000.
  - ROR X=0x01, Y=1 -> Result=0x80, CNVZ=1100.
  - SHR with Y=0 -> Result=X, C=0, Done at 2 cycles.
- Multiply:
  - MULLO X=15, Y=17 -> Done at 10 cycles, Result=0xFF, CNVZ=0100.
  - MULLO X=16, Y=16 -> Result=0x00, CNVZ=1011.
  - MULHI X=16, Y=16 -> Result=0x01, CNVZ=0000.
- Start pulsed every cycle during a MULLO -> exactly one Done, result of the first operation only. The next Start after Done is accepted.
- Resetn low mid-MUL (cycle 4) -> Busy, Done, Result and CNVZ all 0 immediately, no Done afterwards. A following ADD 0x02+0x03 -> 0x05, CNVZ=0000.
